// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, reads the instruction memory,
// buffers {pc, instr} pairs in a small prefetch queue and hands them to
// decode. Handles branch redirects, stalls, halt on a zero word and a
// sticky fault on misaligned redirect targets.
//
// Handshake: an entry transfers to decode on a rising edge where
// out_valid && out_ready. out_valid/out_instr/out_pc come from registers
// only and hold steady while out_valid && !out_ready.
module fetch_sequencer #(
  parameter int              AW       = 12,
  parameter int              DW       = 32,
  parameter int              DEPTH    = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  output logic [DW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  input  logic          out_ready,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    state_dbg
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [DW-1:0] q_instr [DEPTH];
  logic [AW-1:0] q_pc    [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic pop;
  logic redir;
  logic redir_aligned;
  logic fetch;
  logic zero_word;
  logic push;

  // In-cycle event decode; a redirect (outside FAULT) overrides fetch and pop.
  always_comb begin
    pop           = out_valid && out_ready;
    redir         = redirect_valid && (state != S_FAULT);
    redir_aligned = redir && (redirect_pc[1:0] == 2'b00);
    fetch         = (state == S_RUN) && !redir &&
                    ((count < CW'(DEPTH)) || pop);
    zero_word     = (imem_data == '0);
    push          = fetch && !zero_word;
  end

  // Control state, PC, queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redir) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redir_aligned) begin
        pc    <= redirect_pc;
        state <= S_RUN;
      end else begin
        state <= S_FAULT;
      end
    end else begin
      case (state)
        S_IDLE:  if (start) state <= S_RUN;
        S_RUN:   if (fetch && zero_word) state <= S_HALT;
        default: state <= state;
      endcase
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        pc     <= pc + AW'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_data;
      q_pc[wr_ptr]    <= pc;
    end
  end

  // Outputs are pure functions of registered state.
  always_comb begin
    imem_addr = pc;
    out_valid = (count != '0);
    out_instr = out_valid ? q_instr[rd_ptr] : '0;
    out_pc    = out_valid ? q_pc[rd_ptr] : '0;
    halted    = (state == S_HALT);
    fault     = (state == S_FAULT);
    state_dbg = state;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural instruction memory.
module tb_fetch_sequencer;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          out_ready = 1'b0;
  logic          halted;
  logic          fault;
  logic [1:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_q[$];

  logic [DW-1:0] mem [0:1023];
  assign imem_data = mem[imem_addr[11:2]];

  fetch_sequencer #(.AW(AW), .DW(DW), .DEPTH(2), .RESET_PC(12'd0)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .halted(halted), .fault(fault),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] p);
    return 32'hA000_0000 | {22'd0, p[11:2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = word_at(AW'(i * 4));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // start pulse in cycle 0; returns at cycle 1
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    fill_mem();
    do_reset();

    // reset state
    check("rst_valid",  32'(out_valid), 32'd0);
    check("rst_instr",  out_instr, 32'd0);
    check("rst_pc",     32'(out_pc), 32'd0);
    check("rst_addr",   32'(imem_addr), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_fault",  32'(fault), 32'd0);
    check("rst_state",  32'(state_dbg), 32'(ST_IDLE));

    // idle without start: nothing fetched
    step();
    check("idle_addr", 32'(imem_addr), 32'd0);

    // 1: straight-line run into a zero word at 0x00C
    mem[3] = 32'h0;
    out_ready = 1'b1;
    do_start();
    check("t1_c1_state", 32'(state_dbg), 32'(ST_RUN));
    check("t1_c1_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_pc",    32'(out_pc), 32'(k * 4));
      check("t1_instr", out_instr, word_at(AW'(k * 4)));
    end
    check("t1_pre_halt", 32'(halted), 32'd0);
    step();
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_drained", 32'(out_valid), 32'd0);
    check("t1_pc_hold", 32'(imem_addr), 32'h00C);
    step();
    check("t1_still_halt", 32'(state_dbg), 32'(ST_HALT));
    mem[3] = word_at(12'h00C);

    // 2: stall with out_ready=0, then release through the scoreboard
    do_reset();
    do_start();
    step(); step();
    for (int c = 3; c <= 5; c++) begin
      check("t2_stall_addr",  32'(imem_addr), 32'h008);
      check("t2_stall_pc",    32'(out_pc), 32'h000);
      check("t2_stall_instr", out_instr, word_at(12'h000));
      check("t2_stall_valid", 32'(out_valid), 32'd1);
      if (c < 5) step();
    end
    for (int k = 0; k < 5; k++) exp_q.push_back(AW'(k * 4));
    out_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [AW-1:0] e;
      e = exp_q.pop_front();
      check("t2_drain_valid", 32'(out_valid), 32'd1);
      check("t2_drain_pc",    32'(out_pc), 32'(e));
      check("t2_drain_instr", out_instr, word_at(e));
      step();
    end

    // 3: redirect to 0x020 with a full queue (pop same cycle ignored)
    do_reset();
    do_start();
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 12'h020; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("t3_bubble", 32'(out_valid), 32'd0);
    check("t3_addr",   32'(imem_addr), 32'h020);
    step();
    check("t3_valid", 32'(out_valid), 32'd1);
    check("t3_pc",    32'(out_pc), 32'h020);
    check("t3_instr", out_instr, word_at(12'h020));
    step();
    check("t3_pc_next", 32'(out_pc), 32'h024);

    // 4: misaligned redirect -> sticky fault, PC unchanged
    check("t4_addr_before", 32'(imem_addr), 32'h028);
    redirect_valid = 1'b1; redirect_pc = 12'h022;
    step();
    redirect_valid = 1'b0;
    check("t4_fault", 32'(fault), 32'd1);
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_state", 32'(state_dbg), 32'(ST_FAULT));
    check("t4_addr",  32'(imem_addr), 32'h028);
    redirect_valid = 1'b1; redirect_pc = 12'h000;
    step();
    redirect_valid = 1'b0;
    step(); step();
    check("t4_ignored_fault", 32'(fault), 32'd1);
    check("t4_ignored_valid", 32'(out_valid), 32'd0);
    check("t4_ignored_addr",  32'(imem_addr), 32'h028);
    do_reset();
    check("t4_rst_fault", 32'(fault), 32'd0);
    check("t4_rst_state", 32'(state_dbg), 32'(ST_IDLE));

    // 5: redirect to 0xFF8, fetch wraps past the top of memory
    out_ready = 1'b1;
    do_start();
    redirect_valid = 1'b1; redirect_pc = 12'hFF8;
    step();
    redirect_valid = 1'b0;
    check("t5_bubble", 32'(out_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] p;
      p = 12'hFF8 + AW'(k * 4);
      step();
      check("t5_pc",    32'(out_pc), 32'(p));
      check("t5_instr", out_instr, word_at(p));
    end

    // 6: reset during a stall with a full queue and a pending redirect
    do_reset();
    do_start();
    step(); step(); step();
    check("t6_full_valid", 32'(out_valid), 32'd1);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h040;
    step();
    reset = 1'b0; redirect_valid = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    check("t6_addr",  32'(imem_addr), 32'h000);
    check("t6_state", 32'(state_dbg), 32'(ST_IDLE));

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
